// File: rtl/secret_key_writer_if.sv
// Byte-stream write channel for secret_key_writer: valid/ready handshake plus data and frame end.
interface secret_key_writer_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       wr_last;

    modport master (output wr_valid, output wr_data, output wr_last, input wr_ready);
    modport slave  (input wr_valid, input wr_data, input wr_last, output wr_ready);
endinterface

// File: rtl/secret_key_writer.sv
// Assembles a framed 32-bit key from byte beats and commits it atomically; sticky lock until reset.
// Optional SECRET_KEY_WRITER_CHECKSUM_EN adds a fifth XOR checksum beat to every frame.
module secret_key_writer (
    input  logic                clk,
    input  logic                rst_n,
    secret_key_writer_if.slave  wr,
    input  logic                lock_req_i,
    output logic [31:0]         key_out_o,
    output logic                key_valid_o,
    output logic                commit_done_o,
    output logic                err_o,
    output logic                locked_o
);

`ifdef SECRET_KEY_WRITER_CHECKSUM_EN
    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] LAST_IDX = 3'd4;
`else
    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] LAST_IDX = 2'd3;
`endif
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_COMMIT = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_LOCKED = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      shadow_q, shadow_d;
    logic [31:0]      key_q, key_d;
    logic             key_valid_q, key_valid_d;
    logic             commit_done_q, commit_done_d;
    logic             err_q, err_d;
    logic             locked_q, locked_d;
    logic             wr_ready_s;
    logic             beat_s;

    // Lane indices beyond 3 (the checksum beat) leave the shadow untouched.
    function automatic logic [31:0] put_lane(input logic [31:0] shadow,
                                             input logic [CNT_W-1:0] lane,
                                             input logic [7:0] data);
        logic [31:0] res;
        res = shadow;
        for (int i = 0; i < 4; i++) begin
            if (int'(lane) == i) begin
                res[8*i +: 8] = data;
            end else begin
                res[8*i +: 8] = res[8*i +: 8];
            end
        end
        return res;
    endfunction

`ifdef SECRET_KEY_WRITER_CHECKSUM_EN
    function automatic logic [7:0] frame_xor(input logic [31:0] v);
        return v[7:0] ^ v[15:8] ^ v[23:16] ^ v[31:24];
    endfunction
`endif

    // Ready is a pure function of state and lock_req, never of wr_valid.
    always_comb begin
        wr_ready_s = 1'b0;
        case (state_q)
            ST_IDLE:  wr_ready_s = ~lock_req_i;
            ST_LOAD:  wr_ready_s = 1'b1;
            ST_DRAIN: wr_ready_s = 1'b1;
            default:  wr_ready_s = 1'b0;
        endcase
    end

    assign beat_s      = wr.wr_valid & wr_ready_s;
    assign wr.wr_ready = wr_ready_s;

    // Frame FSM next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shadow_d      = shadow_q;
        key_d         = key_q;
        key_valid_d   = key_valid_q;
        commit_done_d = 1'b0;
        err_d         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = CNT_ZERO;
                if (lock_req_i) begin
                    state_d = ST_LOCKED;
                end else if (beat_s) begin
                    if (wr.wr_last) begin
                        err_d    = 1'b1;
                        shadow_d = 32'h0000_0000;
                    end else begin
                        shadow_d = put_lane(shadow_q, CNT_ZERO, wr.wr_data);
                        cnt_d    = CNT_ONE;
                        state_d  = ST_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (beat_s) begin
                    shadow_d = put_lane(shadow_q, cnt_q, wr.wr_data);
                    if (cnt_q != LAST_IDX) begin
                        if (wr.wr_last) begin
                            err_d    = 1'b1;
                            shadow_d = 32'h0000_0000;
                            cnt_d    = CNT_ZERO;
                            state_d  = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else if (wr.wr_last) begin
`ifdef SECRET_KEY_WRITER_CHECKSUM_EN
                        if (wr.wr_data == frame_xor(shadow_q)) begin
                            state_d = ST_COMMIT;
                        end else begin
                            err_d    = 1'b1;
                            shadow_d = 32'h0000_0000;
                            cnt_d    = CNT_ZERO;
                            state_d  = ST_IDLE;
                        end
`else
                        state_d = ST_COMMIT;
`endif
                    end else begin
                        err_d    = 1'b1;
                        shadow_d = 32'h0000_0000;
                        cnt_d    = CNT_ZERO;
                        state_d  = ST_DRAIN;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_COMMIT: begin
                key_d         = shadow_q;
                key_valid_d   = 1'b1;
                commit_done_d = 1'b1;
                shadow_d      = 32'h0000_0000;
                cnt_d         = CNT_ZERO;
                state_d       = ST_IDLE;
            end
            ST_DRAIN: begin
                cnt_d = CNT_ZERO;
                if (beat_s && wr.wr_last) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_LOCKED: begin
                err_d   = wr.wr_valid;
                state_d = ST_LOCKED;
            end
            default: begin
                state_d  = ST_IDLE;
                shadow_d = 32'h0000_0000;
                cnt_d    = CNT_ZERO;
            end
        endcase
        locked_d = (state_d == ST_LOCKED);
    end

    // State and output registers; reset discards any partial frame and the key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= CNT_ZERO;
            shadow_q      <= 32'h0000_0000;
            key_q         <= 32'h0000_0000;
            key_valid_q   <= 1'b0;
            commit_done_q <= 1'b0;
            err_q         <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            key_q         <= key_d;
            key_valid_q   <= key_valid_d;
            commit_done_q <= commit_done_d;
            err_q         <= err_d;
            locked_q      <= locked_d;
        end
    end

    assign key_out_o     = key_q;
    assign key_valid_o   = key_valid_q;
    assign commit_done_o = commit_done_q;
    assign err_o         = err_q;
    assign locked_o      = locked_q;

endmodule

// File: tb/tb_secret_key_writer.sv
// Self-checking bench for secret_key_writer: directed scenarios plus random frames against a frame-level model.
module tb_secret_key_writer;

`ifdef SECRET_KEY_WRITER_CHECKSUM_EN
    localparam int FRAME_N = 5;
`else
    localparam int FRAME_N = 4;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lock_req;
    logic [31:0] key_out;
    logic        key_valid;
    logic        commit_done;
    logic        err;
    logic        locked;

    secret_key_writer_if wr_if();

    secret_key_writer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr           (wr_if),
        .lock_req_i   (lock_req),
        .key_out_o    (key_out),
        .key_valid_o  (key_valid),
        .commit_done_o(commit_done),
        .err_o        (err),
        .locked_o     (locked)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          err_cnt = 0;
    int          cdone_cnt = 0;
    logic [31:0] m_key;
    logic        m_valid;
    logic [7:0]  frame_q[$];

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (err) err_cnt++;
        if (commit_done) cdone_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic add_ck();
        logic [7:0] x;
        if (FRAME_N == 5) begin
            x = frame_q[0] ^ frame_q[1] ^ frame_q[2] ^ frame_q[3];
            frame_q.push_back(x);
        end
    endtask

    // Drives every byte of frame_q; returns 1 time unit after the edge accepting the final beat.
    task automatic send_frame(input bit with_last);
        bit acc;
        for (int i = 0; i < frame_q.size(); i++) begin
            acc = 1'b0;
            wr_if.wr_valid = 1'b1;
            wr_if.wr_data  = frame_q[i];
            wr_if.wr_last  = with_last && (i == frame_q.size() - 1);
            for (int t = 0; t < 20 && !acc; t++) begin
                @(negedge clk);
                acc = wr_if.wr_ready;
                @(posedge clk);
                #1;
            end
            chk("beat_accepted", {31'd0, acc}, 32'd1);
        end
        wr_if.wr_valid = 1'b0;
        wr_if.wr_last  = 1'b0;
    endtask

    // Frame-level model: only a well-formed frame (with good checksum, if enabled) commits.
    task automatic run_frame(input string tag);
        int          n;
        bit          ok;
        logic [31:0] k;
        n  = frame_q.size();
        ok = (n == FRAME_N);
        k  = 32'd0;
        if (n >= 4) k = {frame_q[3], frame_q[2], frame_q[1], frame_q[0]};
        if (ok && FRAME_N == 5) ok = (frame_q[4] == (frame_q[0] ^ frame_q[1] ^ frame_q[2] ^ frame_q[3]));
        err_cnt   = 0;
        cdone_cnt = 0;
        send_frame(1'b1);
        repeat (3) @(posedge clk);
        #1;
        if (ok) begin
            m_key   = k;
            m_valid = 1'b1;
        end
        chk({tag, "_err"},    err_cnt,   ok ? 32'd0 : 32'd1);
        chk({tag, "_commit"}, cdone_cnt, ok ? 32'd1 : 32'd0);
        chk({tag, "_key"},    key_out,   m_valid ? m_key : 32'd0);
        chk({tag, "_kvalid"}, {31'd0, key_valid}, {31'd0, m_valid});
        chk({tag, "_ready"},  {31'd0, wr_if.wr_ready}, 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        m_key   = 32'd0;
        m_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        lock_req       = 1'b0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = 8'h00;
        wr_if.wr_last  = 1'b0;
        do_reset();

        chk("rst_key",    key_out, 32'd0);
        chk("rst_kvalid", {31'd0, key_valid},   32'd0);
        chk("rst_cdone",  {31'd0, commit_done}, 32'd0);
        chk("rst_err",    {31'd0, err},         32'd0);
        chk("rst_locked", {31'd0, locked},      32'd0);
        chk("rst_ready",  {31'd0, wr_if.wr_ready}, 32'd1);

        // Commit timing on a well-formed frame.
        frame_q = '{8'h78, 8'h56, 8'h34, 8'h12};
        add_ck();
        err_cnt = 0; cdone_cnt = 0;
        send_frame(1'b1);
        chk("commit_cycle_ready", {31'd0, wr_if.wr_ready}, 32'd0);
        chk("commit_cycle_kvalid", {31'd0, key_valid}, 32'd0);
        @(posedge clk); #1;
        chk("n1_key",    key_out, 32'h1234_5678);
        chk("n1_kvalid", {31'd0, key_valid},   32'd1);
        chk("n1_cdone",  {31'd0, commit_done}, 32'd1);
        @(posedge clk); #1;
        chk("n2_cdone",  {31'd0, commit_done}, 32'd0);
        chk("n2_ready",  {31'd0, wr_if.wr_ready}, 32'd1);
        chk("first_cdone_cnt", cdone_cnt, 32'd1);
        chk("first_err_cnt",   err_cnt,   32'd0);
        m_key = 32'h1234_5678; m_valid = 1'b1;

        frame_q = '{8'hAA, 8'hBB};
        run_frame("short");

        frame_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        run_frame("long");

        frame_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        add_ck();
        run_frame("deadbeef");
        chk("deadbeef_value", key_out, 32'hDEAD_BEEF);

`ifdef SECRET_KEY_WRITER_CHECKSUM_EN
        frame_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
        run_frame("bad_ck");
        frame_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        run_frame("good_ck");
`endif

        // Random frames of varied length, about half well-formed.
        for (int f = 0; f < 24; f++) begin
            n = $urandom_range(1, FRAME_N + 2);
            if ($urandom_range(0, 1) == 1) n = FRAME_N;
            frame_q = {};
            for (int b = 0; b < n; b++) frame_q.push_back(8'($urandom));
            if (n == FRAME_N && FRAME_N == 5 && $urandom_range(0, 2) != 0)
                frame_q[4] = frame_q[0] ^ frame_q[1] ^ frame_q[2] ^ frame_q[3];
            run_frame("rand");
        end

        // Lock wins over a simultaneous beat.
        @(negedge clk);
        lock_req       = 1'b1;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 8'h5A;
        wr_if.wr_last  = 1'b0;
        #1;
        chk("lock_ready", {31'd0, wr_if.wr_ready}, 32'd0);
        @(posedge clk); #1;
        lock_req = 1'b0;
        err_cnt = 0; cdone_cnt = 0;
        chk("locked_set", {31'd0, locked}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        wr_if.wr_valid = 1'b0;
        lock_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        lock_req = 1'b0;
        chk("locked_err_cnt", err_cnt,   32'd4);
        chk("locked_commit",  cdone_cnt, 32'd0);
        chk("locked_key",     key_out,   m_valid ? m_key : 32'd0);
        chk("locked_kvalid",  {31'd0, key_valid}, {31'd0, m_valid});
        chk("locked_ready",   {31'd0, wr_if.wr_ready}, 32'd0);
        chk("locked_hold",    {31'd0, locked}, 32'd1);

        // Reset in mid-frame after a committed key.
        do_reset();
        chk("unlock", {31'd0, locked}, 32'd0);
        frame_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        add_ck();
        run_frame("pre_rst");
        frame_q = '{8'h99, 8'h88};
        send_frame(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_key",    key_out, 32'd0);
        chk("midrst_kvalid", {31'd0, key_valid}, 32'd0);
        chk("midrst_cdone",  {31'd0, commit_done}, 32'd0);
        chk("midrst_err",    {31'd0, err}, 32'd0);
        chk("midrst_locked", {31'd0, locked}, 32'd0);
        do_reset();
        frame_q = '{8'hC3, 8'hB2, 8'hA1, 8'h90};
        add_ck();
        run_frame("post_rst");
        chk("post_rst_value", key_out, 32'h90A1_B2C3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
